// File: rtl/serial2parallel.sv
// ---------------------------------------------------------------------------
// serial2parallel
//
// Assembles LSB-first serial frames of 8 bits into bytes and queues them in a
// small first-word-fall-through FIFO.  A frame is delimited by serial_start
// (with bit 0) and serial_end (with bit 7); any other flag placement is a
// framing violation that discards the partial frame and pulses frame_err.
// Reception never stalls: when the FIFO is full and is not being drained on
// the same edge, a completed byte is dropped and the sticky overflow flag is
// set.
//
// Parameters
//   DEPTH         FIFO entries (power of 2, >= 2)
//
// Ports
//   clk           rising-edge clock for all state
//   rst_n         asynchronous, active-low reset
//   d             serial data bit, LSB first, one bit per clock
//   serial_start  high with bit 0 of a frame
//   serial_end    high with bit 7 of a frame
//   data_out      FIFO head byte, 8'h00 while the FIFO is empty
//   out_valid     FIFO non-empty
//   out_ready     consumer accepts the head byte on out_valid & out_ready
//   busy          high while a frame is being received
//   frame_err     one-cycle registered pulse on a framing violation
//   overflow      sticky flag, set when a completed byte is dropped
//   clr_ovf       synchronous clear of overflow (a new set wins)
// ---------------------------------------------------------------------------
module serial2parallel #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d,
  input  logic       serial_start,
  input  logic       serial_end,
  output logic [7:0] data_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  asm_reg;

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        push;
  logic [7:0]  push_byte;
  logic        pop;
  logic        full;
  logic        push_ok;
  logic        drop;

  // A byte completes only on a clean bit 7: serial_end alone, with no restart.
  assign push      = (state == RECV) && !serial_start && serial_end && (idx == 3'd7);
  assign push_byte = {d, asm_reg[6:0]};

  assign full      = (count == FULL_COUNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;

  assign data_out  = out_valid ? mem[rd_ptr] : 8'h00;
  assign busy      = (state == RECV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      asm_reg   <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (serial_start && !serial_end) begin
            asm_reg <= {7'b0, d};
            idx     <= 3'd1;
            state   <= RECV;
          end else if (serial_start && serial_end) begin
            frame_err <= 1'b1;
          end
        end
        RECV: begin
          if (serial_start) begin
            // Restart: drop the partial frame and begin a new one with this
            // bit, unless serial_end arrives too, which abandons everything.
            frame_err <= 1'b1;
            if (serial_end) begin
              asm_reg <= 8'h00;
              idx     <= 3'd0;
              state   <= IDLE;
            end else begin
              asm_reg <= {7'b0, d};
              idx     <= 3'd1;
            end
          end else if (idx == 3'd7) begin
            // Bit 7 always ends the frame; it is only good with serial_end.
            frame_err <= !serial_end;
            asm_reg   <= 8'h00;
            idx       <= 3'd0;
            state     <= IDLE;
          end else if (serial_end) begin
            frame_err <= 1'b1;
            asm_reg   <= 8'h00;
            idx       <= 3'd0;
            state     <= IDLE;
          end else begin
            asm_reg[idx] <= d;
            idx          <= idx + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage is not reset; out_valid gates data_out while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_byte;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial2parallel.sv
// ---------------------------------------------------------------------------
// tb_serial2parallel
//
// Directed and randomized frames for serial2parallel.  Expected outputs come
// from a reference model held in the bench: a queue of delivered bytes, a
// count of bits collected for the current frame, and the framing rules.
// ---------------------------------------------------------------------------
module tb_serial2parallel;

  localparam int DEPTH = 2;

  logic       clk;
  logic       rst_n;
  logic       d;
  logic       serial_start;
  logic       serial_end;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       frame_err;
  logic       overflow;
  logic       clr_ovf;

  int tests_run;
  int tests_failed;

  // Reference model state
  bit         m_in_frame;
  int         m_nbits;
  logic [7:0] m_partial;
  logic [7:0] m_queue[$];
  bit         m_ovf;
  bit         m_ferr;

  serial2parallel #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .d            (d),
    .serial_start (serial_start),
    .serial_end   (serial_end),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Compare every output against the model's view of the current cycle.
  task automatic checkOutput(input string tag);
    logic [7:0] exp_data;
    exp_data = (m_queue.size() > 0) ? m_queue[0] : 8'h00;
    checkVal({tag, ".data_out"},  data_out,         exp_data);
    checkVal({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, m_queue.size() > 0});
    checkVal({tag, ".busy"},      {7'b0, busy},      {7'b0, m_in_frame});
    checkVal({tag, ".frame_err"}, {7'b0, frame_err}, {7'b0, m_ferr});
    checkVal({tag, ".overflow"},  {7'b0, overflow},  {7'b0, m_ovf});
  endtask

  function automatic void modelReset();
    m_in_frame = 1'b0;
    m_nbits    = 0;
    m_partial  = 8'h00;
    m_queue.delete();
    m_ovf      = 1'b0;
    m_ferr     = 1'b0;
  endfunction

  // One clock edge of the model, from the inputs present at that edge.
  function automatic void modelStep(input bit s, input bit e, input bit b, input bit rdy, input bit clr);
    bit         do_push;
    bit         do_pop;
    bit         was_full;
    logic [7:0] new_byte;
    do_push  = 1'b0;
    new_byte = 8'h00;
    m_ferr   = 1'b0;
    if (!m_in_frame) begin
      if (s && !e) begin
        m_in_frame = 1'b1;
        m_partial  = 8'h00;
        m_partial[0] = b;
        m_nbits    = 1;
      end else if (s && e) begin
        m_ferr = 1'b1;
      end
    end else if (s) begin
      m_ferr = 1'b1;
      if (e) begin
        m_in_frame = 1'b0;
      end else begin
        m_partial    = 8'h00;
        m_partial[0] = b;
        m_nbits      = 1;
      end
    end else if (m_nbits == 7) begin
      m_in_frame = 1'b0;
      if (e) begin
        new_byte    = m_partial;
        new_byte[7] = b;
        do_push     = 1'b1;
      end else begin
        m_ferr = 1'b1;
      end
    end else if (e) begin
      m_in_frame = 1'b0;
      m_ferr     = 1'b1;
    end else begin
      m_partial[m_nbits] = b;
      m_nbits++;
    end

    was_full = (m_queue.size() == DEPTH);
    do_pop   = (m_queue.size() > 0) && rdy;
    if (do_pop) void'(m_queue.pop_front());
    if (do_push) begin
      if (was_full && !do_pop) m_ovf = 1'b1;
      else m_queue.push_back(new_byte);
    end else if (clr) begin
      m_ovf = 1'b0;
    end
    if (do_push && was_full && !do_pop) m_ovf = 1'b1;
    else if (clr && !(do_push && was_full && !do_pop)) m_ovf = 1'b0;
  endfunction

  // Drive one cycle's inputs, clock them in, and check the result.
  task automatic applyStimulus(input bit s, input bit e, input bit b, input bit rdy, input bit clr, input string tag);
    serial_start = s;
    serial_end   = e;
    d            = b;
    out_ready    = rdy;
    clr_ovf      = clr;
    @(posedge clk);
    modelStep(s, e, b, rdy, clr);
    #1;
    checkOutput(tag);
  endtask

  task automatic sendByte(input logic [7:0] value, input bit rdy, input string tag);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i == 0, i == 7, value[i], rdy, 1'b0, tag);
    end
  endtask

  task automatic idleCycles(input int n, input bit rdy, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), rdy, 1'b0, tag);
    end
  endtask

  task automatic pulseReset(input string tag);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, ".asserted"});
    @(posedge clk);
    #1;
    checkOutput({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] val;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    d            = 1'b0;
    serial_start = 1'b0;
    serial_end   = 1'b0;
    out_ready    = 1'b0;
    clr_ovf      = 1'b0;
    modelReset();
    #2;
    checkOutput("reset");
    #10;
    rst_n = 1'b1;
    idleCycles(2, 1'b1, "post_reset");

    // Single clean byte delivered and popped right away.
    sendByte(8'hA5, 1'b1, "a5");
    checkVal("a5.head", data_out, 8'hA5);
    idleCycles(2, 1'b1, "a5_drain");

    // Back-to-back bytes into a blocked FIFO, third one overflows.
    sendByte(8'h3C, 1'b0, "ovf_b0");
    sendByte(8'hC3, 1'b0, "ovf_b1");
    sendByte(8'hFF, 1'b0, "ovf_b2");
    checkVal("ovf.sticky", {7'b0, overflow}, 8'h01);
    idleCycles(1, 1'b0, "ovf_hold");
    checkVal("ovf.head0", data_out, 8'h3C);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ovf_pop0");
    checkVal("ovf.head1", data_out, 8'hC3);
    idleCycles(2, 1'b1, "ovf_pop1");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ovf_clear");

    // Early serial_end on bit 4.
    val = 8'h6B;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 0, i == 4, val[i], 1'b1, 1'b0, "early_end");
    end
    idleCycles(2, 1'b1, "early_end_idle");

    // Restart at bit 5, then a clean 0x81.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 0, 1'b0, val[i], 1'b1, 1'b0, "restart_partial");
    end
    val = 8'h81;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i == 0, i == 7, val[i], 1'b1, 1'b0, "restart_81");
    end
    checkVal("restart.head", data_out, 8'h81);
    idleCycles(2, 1'b1, "restart_idle");

    // Reset mid-frame, then a stray bit 7 with no start, then 0x5A.
    val = 8'h77;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i == 0, 1'b0, val[i], 1'b0, 1'b0, "rst_partial");
    end
    pulseReset("midframe_reset");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "rst_stray_end");
    sendByte(8'h5A, 1'b0, "rst_5a");
    checkVal("rst.head", data_out, 8'h5A);
    idleCycles(2, 1'b1, "rst_drain");

    // Full FIFO with a pop on the same edge as the push.
    sendByte(8'h11, 1'b0, "fullpop_b0");
    sendByte(8'h22, 1'b0, "fullpop_b1");
    val = 8'h33;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i == 0, i == 7, val[i], i == 7, 1'b0, "fullpop_b2");
    end
    checkVal("fullpop.head", data_out, 8'h22);
    idleCycles(1, 1'b1, "fullpop_pop");
    checkVal("fullpop.tail", data_out, 8'h33);
    idleCycles(2, 1'b1, "fullpop_drain");

    // Double flag in IDLE.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "idle_both");
    idleCycles(1, 1'b1, "idle_both_after");

    // Randomized frames with occasional errors, gaps, stalls and clears.
    for (int f = 0; f < 60; f++) begin
      int kind;
      int cut;
      val  = 8'($urandom);
      kind = $urandom_range(0, 9);
      cut  = $urandom_range(1, 7);
      for (int i = 0; i < 8; i++) begin
        bit s;
        bit e;
        s = (i == 0) || (kind == 8 && i == cut);
        e = (kind == 9) ? (i == cut) : (i == 7);
        if (kind == 7 && i == 7) e = 1'b0;
        applyStimulus(s, e, val[i], 1'($urandom_range(0, 2) != 0),
                      1'($urandom_range(0, 7) == 0), "rand");
        if (kind == 9 && i == cut) break;
      end
      idleCycles($urandom_range(0, 2), 1'($urandom_range(0, 1)), "rand_gap");
    end
    idleCycles(4, 1'b1, "final_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial2parallel.md
SERIAL2PARALLEL -- requirements
Module: serial2parallel

Interface
REQ-001 Parameter: DEPTH, default 2, output FIFO entries (power of 2, >= 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 d  input  1  serial data bit, LSB first, one bit per clk.
REQ-005 serial_start  input  1  high with bit 0 of a frame.
REQ-006 serial_end  input  1  high with bit 7 of a frame.
REQ-007 data_out  output  8  FIFO head byte; 8'h00 when out_valid=0.
REQ-008 out_valid  output  1  FIFO non-empty.
REQ-009 out_ready  input  1  consumer accepts head when out_valid&out_ready at clk edge.
REQ-010 busy  output  1  high while state is RECV.
REQ-011 frame_err  output  1  one-cycle registered pulse on framing violation.
REQ-012 overflow  output  1  sticky, set when a complete byte is dropped because the FIFO is full.
REQ-013 clr_ovf  input  1  synchronous clear of overflow; set takes priority on the same cycle.

Function
REQ-014 The block SHALL implement FSM states IDLE and RECV, with a 3-bit bit index and an 8-bit assembly register.
REQ-015 IDLE: serial_start=1 and serial_end=0 SHALL store d in bit 0, set index=1, and go to RECV; all other inputs SHALL be ignored.
REQ-016 IDLE: serial_start=1 and serial_end=1 together SHALL pulse frame_err and remain in IDLE.
REQ-017 RECV with index<7, both flags 0: the block SHALL store d in bit[index] and increment index.
REQ-018 RECV with index=7, serial_end=1, serial_start=0: the block SHALL store d in bit 7, push the completed byte, and go to IDLE.
REQ-019 RECV with index=7 and serial_end=0: the block SHALL discard the frame, pulse frame_err, and go to IDLE.
REQ-020 RECV with serial_end=1 and index<7: the block SHALL discard the frame, pulse frame_err, and go to IDLE.
REQ-021 RECV with serial_start=1: the block SHALL pulse frame_err, discard the partial frame, store d in bit 0, set index=1, and stay in RECV; if serial_end=1 in the same cycle, it SHALL discard and go to IDLE.
REQ-022 A pushed byte SHALL appear on data_out with out_valid=1 in the cycle after the edge that sampled bit 7 (latency 1).
REQ-023 The FIFO SHALL be first-word-fall-through, DEPTH entries, with wrap-around pointers and an occupancy count of width clog2(DEPTH)+1.
REQ-024 A pop SHALL occur on an edge where out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-025 A push while full without a simultaneous pop SHALL drop the byte, set overflow, and leave FIFO contents unchanged.
REQ-026 A push and pop on the same edge SHALL both be performed, including when full; occupancy SHALL then be unchanged.
REQ-027 Frame reception SHALL never stall; FIFO state SHALL not affect the FSM.

Reset
REQ-028 With rst_n=0, the block SHALL immediately force FSM=IDLE, index=0, assembly register=0, FIFO empty (pointers and count 0), data_out=8'h00, out_valid=0, busy=0, frame_err=0, overflow=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, the first frame SHALL require a new serial_start.
REQ-030 Reset release SHALL take effect on the first clk edge with rst_n=1.

Verification
REQ-031 Send 8'hA5 LSB first (start on bit 0, end on bit 7) with out_ready=1 -> data_out=8'hA5 and out_valid=1 for one cycle starting the cycle after bit 7; frame_err stays 0.
REQ-032 Send 8'h3C, 8'hC3, 8'hFF back-to-back with DEPTH=2 and out_ready=0 -> first two bytes held in order; third dropped; overflow=1; then out_ready=1 -> 8'h3C then 8'hC3 are popped.
REQ-033 Assert serial_end on bit 4 -> frame_err one-cycle pulse; no push; busy=0 next cycle.
REQ-034 Assert serial_start again at bit 5, then send a clean 8'h81 -> one frame_err pulse; only 8'h81 is delivered.
REQ-035 Pull rst_n low at bit 3 of a frame, release it, then send 8'h5A -> all outputs are 0 during reset; afterwards only 8'h5A is delivered.
REQ-036 With the FIFO full, complete a frame on the same edge as a pop -> no overflow; the new byte is appended; occupancy stays 2.
